axi_stream_remove_header: RTL and testbench
===========================================

Name: axi_stream_remove_header

Overview:
- Receive-side counterpart of the header-insert block. It strips byte_remove_cnt leading header bytes from the first beat of each AXI-Stream packet.
- It realigns the remaining payload to beat boundaries and emits it on an AXI-Stream master with correct keep and last.
- It sits at the ingress of a packet path, after the link and before payload processing.

Parameters:
- DATA_WD, 32, data bus width in bits.
- DATA_BYTE_WD, DATA_WD/8, bytes per beat (N).
- CNT_WD, $clog2(DATA_BYTE_WD), width of byte_remove_cnt.

Ports:
- clk  in  1  clock; all logic on posedge.
- rst  in  1  synchronous, active-high reset.
- valid_in  in  1  input beat valid.
- data_in  in  DATA_WD  input data; byte 0 = data_in[DATA_WD-1 -: 8].
- keep_in  in  DATA_BYTE_WD  byte enables; bit N-1 = byte 0.
- last_in  in  1  final beat of packet.
- ready_in  out  1  input beat accepted when valid_in & ready_in.
- valid_remove  in  1  header-length command valid.
- byte_remove_cnt  in  CNT_WD  header bytes h to strip, 0..N-1.
- ready_remove  out  1  command accepted when valid_remove & ready_remove.
- valid_out  out  1  output beat valid.
- data_out  out  DATA_WD  realigned payload.
- keep_out  out  DATA_BYTE_WD  left-justified byte enables.
- last_out  out  1  final payload beat.
- ready_out  in  1  downstream ready.

Behaviour:
- Reset values: ready_remove=1; ready_in, valid_out, last_out = 0; data_out, keep_out = 0; residual register cleared; state=IDLE.
- Input rules: keep_in is all-ones on non-last beats. On the last beat keep_in is contiguous from the MSB (v valid bytes, 1..N). Other keep patterns are undefined.
- States:
  - IDLE: ready_remove=1, ready_in=0. A command handshake latches h and moves to FIRST.
  - FIRST: ready_in=1. The accepted beat's low N-h bytes go to the residual (byte count r=N-h) and no output is produced.
    - If last_in is set on this beat: when v>h, emit one beat of v-h bytes with last_out=1 and go to DRAIN; when v<=h, emit nothing and return to IDLE.
    - Otherwise go to STREAM.
  - STREAM: accepting beat k emits {residual, top h bytes of beat k} with keep all-ones. The low N-h bytes of beat k become the new residual.
    - If beat k is last with v<=h, the output holds r+v bytes, keep=leftmask(r+v), last_out=1; go to DRAIN.
    - If beat k is last with v>h, the output beat is full with last_out=0; go to FLUSH.
  - FLUSH: ready_in=0. Emit v-h residual bytes with keep=leftmask(v-h) and last_out=1, then go to DRAIN.
  - DRAIN: wait until the output register is empty, then go to IDLE.
- Special case h=0: the residual is a full beat, so the block is a one-beat-latency pass-through with keep and last preserved.
- Output register:
  - Single output register with skid-free backpressure: ready_in = state-allows & (!valid_out | ready_out).
  - data_out, keep_out and last_out stay stable while valid_out & !ready_out.
- Latency:
  - In general, the output beat for input beat k (k>=1) is valid on the cycle after beat k is accepted.
  - First beat: no output.
  - Exception: a single-beat packet with v>h emits its only beat on the cycle after the first beat.
- No bubbles in steady state with ready_out=1.
- Simultaneous events: a command handshake is legal only in IDLE. A command presented early waits with no side effect.
- Reset mid-packet: state, residual and the output register clear on the next posedge. A partial packet is discarded and the next command starts cleanly.

Optional Feature:
- Macro: AXIS_RH_HDR_PORT_EN.
- Defined: adds ports valid_hdr out 1, data_hdr out DATA_WD, keep_hdr out DATA_BYTE_WD, ready_hdr in 1.
  - In FIRST, when h>0, the top h bytes are left-justified onto data_hdr (other bytes zero), keep_hdr=leftmask(h) and valid_hdr=1, held until ready_hdr.
  - An unaccepted header blocks ready_remove for the next packet.
  - h=0 emits no header.
  - valid_hdr resets to 0.
- Undefined: header bytes are discarded and the ports do not exist.

Test Plan:
- h=1; beats 0x11223344, 0x55667788, 0x99AABBCC (all keep 1111, last on 3rd) -> outputs 0x22334455/1111, 0x66778899/1111, 0xAABBCC00/1110 with last.
- h=3; beats 0xA1A2A3A4/1111, 0xB1B2B3B4/1100 last -> single output beat 0xA4B1B200, keep 1110, last_out=1.
- h=0; ready_out toggled 1,0,0,0,1 during a 6-beat packet -> output equals input exactly, each beat delayed one cycle; ready_in=0 while stalled; data_out stable; no loss or duplication.
- h=3; single beat 0x01020304/1110 last -> no data_out beat; with AXIS_RH_HDR_PORT_EN, data_hdr=0x01020300, keep_hdr=1110; block returns to IDLE.
- h=2; beats 0xC1C2C3C4, 0xD1D2D3D4/1110 last -> 0xC3C4D1D2/1111, then FLUSH beat 0xD3000000/1000 last.
- Reset after the 2nd beat of a 4-beat packet -> valid_out=0, ready_remove=1 next cycle; the following h=1 packet is output correctly.

Source files
------------

// File: rtl/axi_stream_remove_header.sv
// axi_stream_remove_header: strips h leading header bytes from each AXI-Stream packet and realigns the payload.
// Optional header side-channel enabled by defining AXIS_RH_HDR_PORT_EN.  Rev 1.0
`default_nettype none

module axi_stream_remove_header #(
  parameter int DATA_WD      = 32,
  parameter int DATA_BYTE_WD = DATA_WD / 8,
  parameter int CNT_WD       = $clog2(DATA_BYTE_WD)
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    valid_in,
  input  logic [DATA_WD-1:0]      data_in,
  input  logic [DATA_BYTE_WD-1:0] keep_in,
  input  logic                    last_in,
  output logic                    ready_in,
  input  logic                    valid_remove,
  input  logic [CNT_WD-1:0]       byte_remove_cnt,
  output logic                    ready_remove,
  output logic                    valid_out,
  output logic [DATA_WD-1:0]      data_out,
  output logic [DATA_BYTE_WD-1:0] keep_out,
  output logic                    last_out,
  input  logic                    ready_out
`ifdef AXIS_RH_HDR_PORT_EN
  ,
  output logic                    valid_hdr,
  output logic [DATA_WD-1:0]      data_hdr,
  output logic [DATA_BYTE_WD-1:0] keep_hdr,
  input  logic                    ready_hdr
`endif
);

  localparam int SH_WD = $clog2(DATA_WD) + 1;
  localparam int NC_WD = CNT_WD + 1;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_FIRST  = 3'd1,
    S_STREAM = 3'd2,
    S_FLUSH  = 3'd3,
    S_DRAIN  = 3'd4
  } state_t;

  function automatic logic [DATA_BYTE_WD-1:0] f_leftmask(input logic [NC_WD-1:0] n);
    logic [DATA_BYTE_WD-1:0] m;
    m = '0;
    for (int i = 0; i < DATA_BYTE_WD; i++) begin
      m[DATA_BYTE_WD-1-i] = (i < int'(n));
    end
    return m;
  endfunction

  function automatic logic [DATA_WD-1:0] f_bytes(input logic [DATA_BYTE_WD-1:0] k);
    logic [DATA_WD-1:0] b;
    b = '0;
    for (int i = 0; i < DATA_BYTE_WD; i++) begin
      b[8*i +: 8] = {8{k[i]}};
    end
    return b;
  endfunction

  state_t                  state_q, state_d;
  logic [CNT_WD-1:0]       h_q, h_d;
  logic [DATA_WD-1:0]      res_q, res_d;
  logic [DATA_BYTE_WD-1:0] fkeep_q, fkeep_d;

  logic                    out_valid_q;
  logic [DATA_WD-1:0]      out_data_q;
  logic [DATA_BYTE_WD-1:0] out_keep_q;
  logic                    out_last_q;

  logic                    w_can_load;
  logic                    w_state_rdy;
  logic                    w_accept;
  logic                    w_load;
  logic [DATA_WD-1:0]      w_ld_data;
  logic [DATA_BYTE_WD-1:0] w_ld_keep;
  logic                    w_ld_last;
  logic                    w_hdr_block;

  logic [NC_WD-1:0]        w_v;
  logic [NC_WD-1:0]        w_h_ext;
  logic [NC_WD-1:0]        w_vmh;
  logic [NC_WD-1:0]        w_fill;
  logic                    w_v_gt_h;
  logic [SH_WD-1:0]        w_sh_lo;
  logic [SH_WD-1:0]        w_sh_hi;
  logic [DATA_WD-1:0]      w_beat_lo;
  logic [DATA_WD-1:0]      w_beat_hi;

  // Number of valid bytes on the current beat; keep is contiguous from the MSB.
  always_comb begin
    w_v = '0;
    for (int i = 0; i < DATA_BYTE_WD; i++) begin
      w_v = w_v + NC_WD'(keep_in[i]);
    end
  end

  assign w_h_ext  = {1'b0, h_q};
  assign w_v_gt_h = (w_v > w_h_ext);
  assign w_vmh    = w_v - w_h_ext;
  assign w_fill   = NC_WD'(DATA_BYTE_WD) - w_h_ext + w_v;

  // Residual kept left-justified; the top h bytes of a beat land right-justified.
  // A shift of DATA_WD (h=0) yields zero, which makes h=0 a clean pass-through.
  assign w_sh_lo   = SH_WD'({h_q, 3'b000});
  assign w_sh_hi   = SH_WD'(DATA_WD) - w_sh_lo;
  assign w_beat_lo = data_in << w_sh_lo;
  assign w_beat_hi = data_in >> w_sh_hi;

  assign w_can_load   = !out_valid_q || ready_out;
  assign w_state_rdy  = (state_q == S_FIRST) || (state_q == S_STREAM);
  assign ready_in     = w_state_rdy && w_can_load;
  assign w_accept     = valid_in && ready_in;
  assign ready_remove = (state_q == S_IDLE) && !w_hdr_block;

  always_comb begin
    state_d   = state_q;
    h_d       = h_q;
    res_d     = res_q;
    fkeep_d   = fkeep_q;
    w_load    = 1'b0;
    w_ld_data = '0;
    w_ld_keep = '0;
    w_ld_last = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (valid_remove && ready_remove) begin
          h_d     = byte_remove_cnt;
          state_d = S_FIRST;
        end
      end
      S_FIRST: begin
        if (w_accept) begin
          res_d = w_beat_lo;
          if (last_in) begin
            if (w_v_gt_h) begin
              w_load    = 1'b1;
              w_ld_keep = f_leftmask(w_vmh);
              w_ld_data = w_beat_lo & f_bytes(w_ld_keep);
              w_ld_last = 1'b1;
              state_d   = S_DRAIN;
            end else begin
              state_d = S_IDLE;
            end
          end else begin
            state_d = S_STREAM;
          end
        end
      end
      S_STREAM: begin
        if (w_accept) begin
          res_d  = w_beat_lo;
          w_load = 1'b1;
          if (last_in && !w_v_gt_h) begin
            w_ld_keep = f_leftmask(w_fill);
            w_ld_data = (res_q | w_beat_hi) & f_bytes(w_ld_keep);
            w_ld_last = 1'b1;
            state_d   = S_DRAIN;
          end else begin
            w_ld_keep = '1;
            w_ld_data = res_q | w_beat_hi;
            if (last_in) begin
              fkeep_d = f_leftmask(w_vmh);
              state_d = S_FLUSH;
            end
          end
        end
      end
      S_FLUSH: begin
        if (w_can_load) begin
          w_load    = 1'b1;
          w_ld_keep = fkeep_q;
          w_ld_data = res_q & f_bytes(fkeep_q);
          w_ld_last = 1'b1;
          state_d   = S_DRAIN;
        end
      end
      S_DRAIN: begin
        if (!out_valid_q) begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      h_q     <= '0;
      res_q   <= '0;
      fkeep_q <= '0;
    end else begin
      state_q <= state_d;
      h_q     <= h_d;
      res_q   <= res_d;
      fkeep_q <= fkeep_d;
    end
  end

  // Single output stage: contents only change when empty or being consumed.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_keep_q  <= '0;
      out_last_q  <= 1'b0;
    end else if (w_load) begin
      out_valid_q <= 1'b1;
      out_data_q  <= w_ld_data;
      out_keep_q  <= w_ld_keep;
      out_last_q  <= w_ld_last;
    end else if (ready_out) begin
      out_valid_q <= 1'b0;
    end
  end

  assign valid_out = out_valid_q;
  assign data_out  = out_data_q;
  assign keep_out  = out_keep_q;
  assign last_out  = out_last_q;

`ifdef AXIS_RH_HDR_PORT_EN
  logic                    hdr_valid_q;
  logic [DATA_WD-1:0]      hdr_data_q;
  logic [DATA_BYTE_WD-1:0] hdr_keep_q;
  logic                    w_hdr_load;
  logic [DATA_BYTE_WD-1:0] w_hdr_keep;

  assign w_hdr_load  = (state_q == S_FIRST) && w_accept && (h_q != '0);
  assign w_hdr_keep  = f_leftmask(w_h_ext);
  assign w_hdr_block = hdr_valid_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      hdr_valid_q <= 1'b0;
      hdr_data_q  <= '0;
      hdr_keep_q  <= '0;
    end else if (w_hdr_load) begin
      hdr_valid_q <= 1'b1;
      hdr_data_q  <= data_in & f_bytes(w_hdr_keep);
      hdr_keep_q  <= w_hdr_keep;
    end else if (ready_hdr) begin
      hdr_valid_q <= 1'b0;
    end
  end

  assign valid_hdr = hdr_valid_q;
  assign data_hdr  = hdr_data_q;
  assign keep_hdr  = hdr_keep_q;
`else
  assign w_hdr_block = 1'b0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_axi_stream_remove_header.sv
// Randomized self-checking bench for axi_stream_remove_header against a byte-queue packet model.
`default_nettype none

module tb_axi_stream_remove_header;

  logic        clk = 1'b0;
  logic        rst;
  logic        valid_in;
  logic [31:0] data_in;
  logic [3:0]  keep_in;
  logic        last_in;
  logic        ready_in;
  logic        valid_remove;
  logic [1:0]  byte_remove_cnt;
  logic        ready_remove;
  logic        valid_out;
  logic [31:0] data_out;
  logic [3:0]  keep_out;
  logic        last_out;
  logic        ready_out;
`ifdef AXIS_RH_HDR_PORT_EN
  logic        valid_hdr;
  logic [31:0] data_hdr;
  logic [3:0]  keep_hdr;
  logic        ready_hdr;
`endif

  axi_stream_remove_header #(.DATA_WD(32)) dut (
    .clk(clk), .rst(rst),
    .valid_in(valid_in), .data_in(data_in), .keep_in(keep_in), .last_in(last_in),
    .ready_in(ready_in),
    .valid_remove(valid_remove), .byte_remove_cnt(byte_remove_cnt), .ready_remove(ready_remove),
    .valid_out(valid_out), .data_out(data_out), .keep_out(keep_out), .last_out(last_out),
    .ready_out(ready_out)
`ifdef AXIS_RH_HDR_PORT_EN
    , .valid_hdr(valid_hdr), .data_hdr(data_hdr), .keep_hdr(keep_hdr), .ready_hdr(ready_hdr)
`endif
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errs   = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errs++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [3:0] lm(input int n);
    logic [3:0] m;
    for (int i = 0; i < 4; i++) m[3-i] = (i < n);
    return m;
  endfunction

  function automatic logic [31:0] bm(input logic [3:0] k);
    logic [31:0] m;
    for (int i = 0; i < 4; i++) m[8*i +: 8] = {8{k[i]}};
    return m;
  endfunction

  function automatic int popk(input logic [3:0] k);
    int c = 0;
    for (int i = 0; i < 4; i++) c += int'(k[i]);
    return c;
  endfunction

  logic [36:0] exp_q[$];
  logic [35:0] hexp_q[$];
  bit          ignore_out = 1'b0;
  int          rdy_pct    = 100;
  int          gap_max    = 0;
  logic [31:0] pkt_d[16];
  logic [3:0]  pkt_k[16];

  initial begin
    ready_out = 1'b1;
    forever begin
      @(posedge clk); #1;
      ready_out = ($urandom_range(99) < rdy_pct);
    end
  end

  initial begin
    logic        stall_prev = 1'b0;
    logic [36:0] prev = '0;
    forever begin
      @(negedge clk);
      if (rst) begin
        stall_prev = 1'b0;
      end else begin
        if (stall_prev && !ignore_out)
          chk("hold", {valid_out, data_out, keep_out, last_out}, {1'b1, prev});
        if (valid_out && !ready_out && !ignore_out)
          chk("rdy_in_stall", ready_in, 1'b0);
        if (valid_out && ready_out && !ignore_out) begin
          if (exp_q.size() == 0) chk("extra_beat", valid_out, 1'b0);
          else chk("beat", {data_out, keep_out, last_out}, exp_q.pop_front());
        end
        stall_prev = valid_out && !ready_out;
        prev       = {data_out, keep_out, last_out};
      end
    end
  end

`ifdef AXIS_RH_HDR_PORT_EN
  initial begin
    ready_hdr = 1'b1;
    forever begin
      @(posedge clk); #1;
      ready_hdr = ($urandom_range(99) < 60);
    end
  end

  initial begin
    forever begin
      @(negedge clk);
      if (!rst && valid_hdr && ready_hdr && !ignore_out) begin
        if (hexp_q.size() == 0) chk("extra_hdr", valid_hdr, 1'b0);
        else chk("hdr", {data_hdr, keep_hdr}, hexp_q.pop_front());
      end
    end
  end
`endif

  task automatic idle_cycles(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic send_cmd(input int h);
    int t = 0;
    valid_remove    = 1'b1;
    byte_remove_cnt = h[1:0];
    forever begin
      @(negedge clk);
      if (ready_remove) begin @(posedge clk); #1; break; end
      if (++t > 300) begin chk("cmd_timeout", ready_remove, 1'b1); break; end
    end
    valid_remove = 1'b0;
  endtask

  task automatic send_beat(input logic [31:0] d, input logic [3:0] k, input bit l);
    int t = 0;
    valid_in = 1'b1; data_in = d; keep_in = k; last_in = l;
    forever begin
      @(negedge clk);
      if (ready_in) begin @(posedge clk); #1; break; end
      if (++t > 300) begin chk("in_timeout", ready_in, 1'b1); break; end
    end
    valid_in = 1'b0; last_in = 1'b0;
  endtask

  // Model: concatenate valid bytes, drop h from the front, re-chunk into left-justified beats.
  task automatic send_pkt(input int h, input int nb);
    logic [7:0]  bq[$];
    logic [31:0] d;
    int          v, n;
    for (int b = 0; b < nb; b++) begin
      v = (b == nb - 1) ? popk(pkt_k[b]) : 4;
      for (int i = 0; i < v; i++) bq.push_back(pkt_d[b][31-8*i -: 8]);
    end
    for (int i = 0; i < h; i++) if (bq.size() > 0) void'(bq.pop_front());
`ifdef AXIS_RH_HDR_PORT_EN
    if (h > 0) hexp_q.push_back({pkt_d[0] & bm(lm(h)), lm(h)});
`endif
    while (bq.size() > 0) begin
      d = '0; n = 0;
      while (n < 4 && bq.size() > 0) begin
        d[31-8*n -: 8] = bq.pop_front();
        n++;
      end
      exp_q.push_back({d, lm(n), bq.size() == 0});
    end
    send_cmd(h);
    for (int b = 0; b < nb; b++) begin
      idle_cycles($urandom_range(gap_max));
      send_beat(pkt_d[b], (b == nb - 1) ? pkt_k[b] : 4'hF, b == nb - 1);
    end
  endtask

  task automatic rand_pkt();
    int nb = $urandom_range(6, 1);
    for (int b = 0; b < nb; b++) begin
      pkt_d[b] = $urandom;
      pkt_k[b] = 4'hF;
    end
    pkt_k[nb-1] = lm($urandom_range(4, 1));
    send_pkt($urandom_range(3), nb);
  endtask

  initial begin
    int t;
    rst = 1'b1; valid_in = 1'b0; data_in = '0; keep_in = '0; last_in = 1'b0;
    valid_remove = 1'b0; byte_remove_cnt = '0;
    idle_cycles(3);
    rst = 1'b0;
    @(negedge clk);
    chk("rst_valid_out", valid_out, 1'b0);
    chk("rst_ready_remove", ready_remove, 1'b1);
    chk("rst_ready_in", ready_in, 1'b0);
    chk("rst_last_out", last_out, 1'b0);
    chk("rst_data_out", data_out, 32'h0);
    chk("rst_keep_out", keep_out, 4'h0);
    @(posedge clk); #1;

    pkt_d[0] = 32'h11223344; pkt_d[1] = 32'h55667788; pkt_d[2] = 32'h99AABBCC;
    pkt_k[2] = 4'hF;
    send_pkt(1, 3);
    pkt_d[0] = 32'hA1A2A3A4; pkt_d[1] = 32'hB1B2B3B4; pkt_k[1] = 4'hC;
    send_pkt(3, 2);
    rdy_pct = 50;
    for (int b = 0; b < 6; b++) begin pkt_d[b] = $urandom; pkt_k[b] = 4'hF; end
    send_pkt(0, 6);
    rdy_pct = 100;
    pkt_d[0] = 32'h01020304; pkt_k[0] = 4'hE;
    send_pkt(3, 1);
    pkt_d[0] = 32'hC1C2C3C4; pkt_d[1] = 32'hD1D2D3D4; pkt_k[1] = 4'hE;
    send_pkt(2, 2);

    // Single-beat packet with v>h: its beat must be valid the cycle after acceptance.
    idle_cycles(4);
    pkt_d[0] = 32'hDEADBEEF; pkt_k[0] = 4'hF;
    send_pkt(1, 1);
    @(negedge clk);
    chk("single_latency", {valid_out, last_out}, 2'b11);
    @(posedge clk); #1;
    idle_cycles(4);

    // Reset in the middle of a packet; partial output is discarded.
    ignore_out = 1'b1;
    send_cmd(1);
    send_beat(32'h01234567, 4'hF, 1'b0);
    send_beat(32'h89ABCDEF, 4'hF, 1'b0);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    chk("midrst_valid_out", valid_out, 1'b0);
    chk("midrst_ready_remove", ready_remove, 1'b1);
    @(posedge clk); #1;
    ignore_out = 1'b0;
    pkt_d[0] = 32'h10203040; pkt_d[1] = 32'h50607080; pkt_d[2] = 32'h90A0B0C0;
    pkt_k[2] = 4'hC;
    send_pkt(1, 3);

    for (int p = 0; p < 40; p++) begin
      rdy_pct = $urandom_range(100, 30);
      gap_max = $urandom_range(2);
      rand_pkt();
    end
    rdy_pct = 100;

    t = 0;
    while ((exp_q.size() > 0 || hexp_q.size() > 0) && t < 500) begin
      @(posedge clk); #1;
      t++;
    end
    chk("drain_out", exp_q.size(), 0);
    chk("drain_hdr", hexp_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", n_errs, n_checks);
    $finish;
  end

endmodule

`default_nettype wire
